uc_mc_param: RTL and testbench
==============================

UC_MC_PARAM -- requirements
Module: uc_mc_param

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles per memory access, range 0..7.
REQ-002 SHALL have parameter STATE_W, default 7: width of ESTADO_ATUAL.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port IR31_0  in  32  instruction register contents; opcode is [6:0], funct3 is [14:12], funct7 is [31:25].
REQ-006 SHALL have port ZERO  in  1  ALU zero flag.
REQ-007 SHALL have ports PC_WRITE, IR_WRITE, LOAD_A, LOAD_B, LOAD_ALUOUT, LOAD_MDR, WRITE_REG, MEM_TO_REG, DMEM_RW, ALU_SRCA, RESET_WIRE, EXCEPTION  out  1 each  datapath strobes and selects.
REQ-008 SHALL have ports ALU_SRCB  out  2  and PC_SRC  out  2  operand and PC source selects.
REQ-009 SHALL have port ALU_SELECTOR  out  3  with codes 0 = pass, 1 = add, 2 = sub, 3 = compare.
REQ-010 SHALL have port ESTADO_ATUAL  out  STATE_W  current state encoding.

Function
REQ-011 SHALL default every output to 0 in every state unless that state lists it, so no latches are inferred.
REQ-012 SHALL implement states RESET_ST, BUSCA, SOMA, DECODE, R, ADDI, WB_ALU, LD_ADDR, LD_WAIT, LD_WB, SD_ADDR, SD_WAIT, BRANCH, LUI, TRAP.
REQ-013 RESET_ST SHALL assert RESET_WIRE=1 and move to BUSCA.
REQ-014 BUSCA SHALL last MEM_WAIT+1 cycles and assert IR_WRITE=1 only in its final cycle, then move to SOMA.
REQ-015 SOMA SHALL assert PC_WRITE=1, ALU_SRCB=1, ALU_SELECTOR=1 and PC_SRC=0 (PC+4).
REQ-016 DECODE SHALL assert LOAD_A=1, LOAD_B=1, LOAD_ALUOUT=1, ALU_SRCB=3 and ALU_SELECTOR=1 (branch target PC+imm) and dispatch on opcode as follows:
- 0110011 to R
- 0010011 to ADDI
- 0000011 to LD_ADDR
- 0100011 to SD_ADDR
- 1100011 to BRANCH
- 0110111 to LUI
- any other opcode is illegal.
REQ-017 R SHALL assert ALU_SRCA=1, ALU_SRCB=0 and LOAD_ALUOUT=1, with ALU_SELECTOR=1 for funct7 0000000 and ALU_SELECTOR=2 for funct7 0100000; any other funct7 is illegal.
REQ-018 ADDI SHALL assert ALU_SRCA=1, ALU_SRCB=2, ALU_SELECTOR=1 and LOAD_ALUOUT=1.
REQ-019 LUI SHALL assert ALU_SRCB=2, ALU_SELECTOR=0 and LOAD_ALUOUT=1.
REQ-020 R, ADDI and LUI SHALL all move to WB_ALU.
REQ-021 WB_ALU SHALL assert WRITE_REG=1 and MEM_TO_REG=0, then move to BUSCA.
REQ-022 LD_ADDR and SD_ADDR SHALL assert ALU_SRCA=1, ALU_SRCB=2, ALU_SELECTOR=1 and LOAD_ALUOUT=1.
REQ-023 LD_WAIT SHALL last MEM_WAIT+1 cycles with DMEM_RW=0 and assert LOAD_MDR=1 in its final cycle.
REQ-024 LD_WB SHALL assert WRITE_REG=1 and MEM_TO_REG=1.
REQ-025 SD_WAIT SHALL last MEM_WAIT+1 cycles with DMEM_RW=1 in every cycle, then move to BUSCA.
REQ-026 BRANCH SHALL assert ALU_SRCA=1, ALU_SRCB=0 and ALU_SELECTOR=2.
REQ-027 BRANCH SHALL assert PC_WRITE=1 and PC_SRC=1 when funct3=000 and ZERO=1, or when funct3=001 and ZERO=0; any other funct3 is illegal; BRANCH then moves to BUSCA.
REQ-028 The wait counter SHALL load MEM_WAIT on entry to BUSCA, LD_WAIT or SD_WAIT, decrement each cycle, and permit exit when it reads 0; MEM_WAIT=0 SHALL give single-cycle states.
REQ-029 ESTADO_ATUAL SHALL equal the zero-extended state encoding, with RESET_ST=0 and BUSCA=1.

Reset
REQ-030 RESET=1 at a rising edge SHALL force RESET_ST and clear the wait counter, abandoning any in-progress wait state.
REQ-031 During RESET_ST, RESET_WIRE SHALL be 1 and all other outputs SHALL be 0.

Configuration
REQ-032 With macro UC_TRAP_EN defined, an illegal opcode, funct7 or funct3 SHALL enter TRAP.
REQ-033 TRAP SHALL assert EXCEPTION=1, PC_WRITE=1 and PC_SRC=2 (trap vector) for one cycle, then move to BUSCA.
REQ-034 Without UC_TRAP_EN, illegal encodings SHALL return to BUSCA as a NOP, EXCEPTION SHALL be tied to 0, and TRAP SHALL not be synthesised.

Structure
REQ-035 Package uc_pkg SHALL hold the following shared definitions:
- the state enum
- the opcode, funct3 and funct7 constants
- the ALU_SELECTOR, ALU_SRCB and PC_SRC code constants.
REQ-036 Sub-module uc_wait_cnt (3-bit load/decrement counter with a done flag) SHALL implement the wait counter.

Verification
REQ-037 With MEM_WAIT=0, IR31_0=0x002081B3 (add) SHALL step BUSCA, SOMA, DECODE, R, WB_ALU, taking 5 cycles, with ALU_SELECTOR=1 in R and WRITE_REG=1 only in WB_ALU.
REQ-038 With MEM_WAIT=2, IR31_0=0x0000B183 (ld) SHALL take 10 cycles, with LOAD_MDR=1 exactly once, in the third LD_WAIT cycle, and MEM_TO_REG=1 in LD_WB.
REQ-039 IR31_0=0x00208463 (beq) SHALL give PC_WRITE=1 and PC_SRC=1 in BRANCH when ZERO=1, and PC_WRITE=0 when ZERO=0; funct3=001 (bne) SHALL give the inverse.
REQ-040 IR31_0=0x0000007F SHALL produce a one-cycle EXCEPTION=1 pulse in TRAP with UC_TRAP_EN defined, and a direct return to BUSCA with EXCEPTION=0 without it.
REQ-041 RESET=1 asserted in the second of three SD_WAIT cycles (MEM_WAIT=2) SHALL show RESET_ST on the next cycle, with DMEM_RW=0 and ESTADO_ATUAL=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit: states, decode fields, select codes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uc_pkg;

  // RESET_ST and BUSCA are pinned to 0 and 1; the rest follow in declaration order.
  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    BUSCA    = 4'd1,
    SOMA     = 4'd2,
    DECODE   = 4'd3,
    R        = 4'd4,
    ADDI     = 4'd5,
    WB_ALU   = 4'd6,
    LD_ADDR  = 4'd7,
    LD_WAIT  = 4'd8,
    LD_WB    = 4'd9,
    SD_ADDR  = 4'd10,
    SD_WAIT  = 4'd11,
    BRANCH   = 4'd12,
    LUI      = 4'd13,
    TRAP     = 4'd14
  } state_t;

  // opcode field, IR[6:0]
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_SD     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct3 field, IR[14:12]
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // funct7 field, IR[31:25]
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // ALU_SELECTOR codes
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_CMP  = 3'd3;

  // ALU_SRCB codes
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BIMM = 2'd3;

  // PC_SRC codes
  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;

  // States whose length is stretched by the memory wait counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == BUSCA) || (s == LD_WAIT) || (s == SD_WAIT);
  endfunction

endpackage

// File: rtl/uc_mc_param_if.sv
// Bundle between the control unit and the datapath: IR/ZERO in, strobes/selects out.
// Latency: wires only.
// Backpressure: none; master = control unit, slave = datapath.
interface uc_mc_param_if #(
  parameter int STATE_W = 7
);
  logic [31:0]        IR31_0;
  logic               ZERO;
  logic               PC_WRITE;
  logic               IR_WRITE;
  logic               LOAD_A;
  logic               LOAD_B;
  logic               LOAD_ALUOUT;
  logic               LOAD_MDR;
  logic               WRITE_REG;
  logic               MEM_TO_REG;
  logic               DMEM_RW;
  logic               ALU_SRCA;
  logic               RESET_WIRE;
  logic               EXCEPTION;
  logic [1:0]         ALU_SRCB;
  logic [1:0]         PC_SRC;
  logic [2:0]         ALU_SELECTOR;
  logic [STATE_W-1:0] ESTADO_ATUAL;

  modport master (
    input  IR31_0, ZERO,
    output PC_WRITE, IR_WRITE, LOAD_A, LOAD_B, LOAD_ALUOUT, LOAD_MDR, WRITE_REG,
           MEM_TO_REG, DMEM_RW, ALU_SRCA, RESET_WIRE, EXCEPTION, ALU_SRCB, PC_SRC,
           ALU_SELECTOR, ESTADO_ATUAL
  );

  modport slave (
    output IR31_0, ZERO,
    input  PC_WRITE, IR_WRITE, LOAD_A, LOAD_B, LOAD_ALUOUT, LOAD_MDR, WRITE_REG,
           MEM_TO_REG, DMEM_RW, ALU_SRCA, RESET_WIRE, EXCEPTION, ALU_SRCB, PC_SRC,
           ALU_SELECTOR, ESTADO_ATUAL
  );
endinterface

// File: rtl/uc_wait_cnt.sv
// 3-bit load/decrement wait counter; done is high while the count reads zero.
// Latency: load takes effect the cycle after load is asserted; done is combinational from the count.
// Backpressure: none. Ports: CLK, RESET (sync, high), load, load_val[2:0], done.
module uc_wait_cnt (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       done
);

  logic [2:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign done = (cnt == 3'd0);

endmodule

// File: rtl/uc_mc_param.sv
// Multicycle RISC-V style control unit (fetch/decode/execute FSM) with parameterised memory waits.
// Latency: outputs are decoded combinationally from the current state (plus IR/ZERO).
// Backpressure: fixed MEM_WAIT extra cycles in fetch/load/store. Ports: CLK, RESET (sync, high),
//   bus (uc_mc_param_if.master). Build option: define UC_TRAP_EN to route illegal encodings to TRAP.
module uc_mc_param
  import uc_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int STATE_W  = 7
) (
  input  logic          CLK,
  input  logic          RESET,
  uc_mc_param_if.master bus
);

`ifdef UC_TRAP_EN
  localparam state_t ILLEGAL_NEXT = TRAP;
`else
  // Illegal encodings are treated as a NOP: straight back to fetch.
  localparam state_t ILLEGAL_NEXT = BUSCA;
`endif

  state_t     state, next_state;
  logic       wait_load, wait_done;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_ir_bits;

  assign opcode         = bus.IR31_0[6:0];
  assign funct3         = bus.IR31_0[14:12];
  assign funct7         = bus.IR31_0[31:25];
  assign unused_ir_bits = ^{bus.IR31_0[24:15], bus.IR31_0[11:7]};

  // Reload only when a wait state is freshly entered, not while dwelling in it.
  assign wait_load = is_wait_state(next_state) && (next_state != state);

  uc_wait_cnt u_wait_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (wait_load),
    .load_val (3'(MEM_WAIT)),
    .done     (wait_done)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= RESET_ST;
    else       state <= next_state;
  end

  assign bus.ESTADO_ATUAL = STATE_W'(state);

  always_comb begin
    next_state       = state;
    bus.PC_WRITE     = 1'b0;
    bus.IR_WRITE     = 1'b0;
    bus.LOAD_A       = 1'b0;
    bus.LOAD_B       = 1'b0;
    bus.LOAD_ALUOUT  = 1'b0;
    bus.LOAD_MDR     = 1'b0;
    bus.WRITE_REG    = 1'b0;
    bus.MEM_TO_REG   = 1'b0;
    bus.DMEM_RW      = 1'b0;
    bus.ALU_SRCA     = 1'b0;
    bus.RESET_WIRE   = 1'b0;
    bus.EXCEPTION    = 1'b0;
    bus.ALU_SRCB     = SRCB_REG;
    bus.PC_SRC       = PC_SEQ;
    bus.ALU_SELECTOR = ALU_PASS;

    case (state)
      RESET_ST: begin
        bus.RESET_WIRE = 1'b1;
        next_state     = BUSCA;
      end
      BUSCA: begin
        if (wait_done) begin
          bus.IR_WRITE = 1'b1;
          next_state   = SOMA;
        end
      end
      SOMA: begin
        bus.PC_WRITE     = 1'b1;
        bus.ALU_SRCB     = SRCB_FOUR;
        bus.ALU_SELECTOR = ALU_ADD;
        bus.PC_SRC       = PC_SEQ;
        next_state       = DECODE;
      end
      DECODE: begin
        // ALUOut captures PC+imm here so BRANCH can use it as the target.
        bus.LOAD_A       = 1'b1;
        bus.LOAD_B       = 1'b1;
        bus.LOAD_ALUOUT  = 1'b1;
        bus.ALU_SRCB     = SRCB_BIMM;
        bus.ALU_SELECTOR = ALU_ADD;
        case (opcode)
          OP_R:      next_state = R;
          OP_ADDI:   next_state = ADDI;
          OP_LD:     next_state = LD_ADDR;
          OP_SD:     next_state = SD_ADDR;
          OP_BRANCH: next_state = BRANCH;
          OP_LUI:    next_state = LUI;
          default:   next_state = ILLEGAL_NEXT;
        endcase
      end
      R: begin
        bus.ALU_SRCA    = 1'b1;
        bus.ALU_SRCB    = SRCB_REG;
        bus.LOAD_ALUOUT = 1'b1;
        if (funct7 == F7_ADD) begin
          bus.ALU_SELECTOR = ALU_ADD;
          next_state       = WB_ALU;
        end else if (funct7 == F7_SUB) begin
          bus.ALU_SELECTOR = ALU_SUB;
          next_state       = WB_ALU;
        end else begin
          next_state = ILLEGAL_NEXT;
        end
      end
      ADDI: begin
        bus.ALU_SRCA     = 1'b1;
        bus.ALU_SRCB     = SRCB_IMM;
        bus.ALU_SELECTOR = ALU_ADD;
        bus.LOAD_ALUOUT  = 1'b1;
        next_state       = WB_ALU;
      end
      LUI: begin
        bus.ALU_SRCB     = SRCB_IMM;
        bus.ALU_SELECTOR = ALU_PASS;
        bus.LOAD_ALUOUT  = 1'b1;
        next_state       = WB_ALU;
      end
      WB_ALU: begin
        bus.WRITE_REG  = 1'b1;
        bus.MEM_TO_REG = 1'b0;
        next_state     = BUSCA;
      end
      LD_ADDR, SD_ADDR: begin
        bus.ALU_SRCA     = 1'b1;
        bus.ALU_SRCB     = SRCB_IMM;
        bus.ALU_SELECTOR = ALU_ADD;
        bus.LOAD_ALUOUT  = 1'b1;
        next_state       = (state == LD_ADDR) ? LD_WAIT : SD_WAIT;
      end
      LD_WAIT: begin
        bus.DMEM_RW = 1'b0;
        if (wait_done) begin
          bus.LOAD_MDR = 1'b1;
          next_state   = LD_WB;
        end
      end
      LD_WB: begin
        bus.WRITE_REG  = 1'b1;
        bus.MEM_TO_REG = 1'b1;
        next_state     = BUSCA;
      end
      SD_WAIT: begin
        bus.DMEM_RW = 1'b1;
        if (wait_done) next_state = BUSCA;
      end
      BRANCH: begin
        bus.ALU_SRCA     = 1'b1;
        bus.ALU_SRCB     = SRCB_REG;
        bus.ALU_SELECTOR = ALU_SUB;
        next_state       = BUSCA;
        case (funct3)
          F3_BEQ: begin
            bus.PC_WRITE = bus.ZERO;
            bus.PC_SRC   = bus.ZERO ? PC_BR : PC_SEQ;
          end
          F3_BNE: begin
            bus.PC_WRITE = ~bus.ZERO;
            bus.PC_SRC   = bus.ZERO ? PC_SEQ : PC_BR;
          end
          default: next_state = ILLEGAL_NEXT;
        endcase
      end
`ifdef UC_TRAP_EN
      TRAP: begin
        bus.EXCEPTION = 1'b1;
        bus.PC_WRITE  = 1'b1;
        bus.PC_SRC    = PC_TRAP;
        next_state    = BUSCA;
      end
`endif
      default: next_state = RESET_ST;
    endcase
  end

endmodule

// File: tb/tb_uc_mc_param.sv
// Bench for uc_mc_param: two instances (MEM_WAIT=0 and MEM_WAIT=2) checked cycle by cycle
// against a per-instruction trace model built from the instruction-class rules.
// Inputs change after sampling at negedge; outputs are sampled at negedge.
module tb_uc_mc_param;
  import uc_pkg::*;

`ifdef UC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [6:0] st;
    logic pc_write, ir_write, load_a, load_b, load_aluout, load_mdr;
    logic write_reg, mem_to_reg, dmem_rw, alu_srca, reset_wire, exception;
    logic [1:0] alu_srcb, pc_src;
    logic [2:0] alu_sel;
  } obs_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst0, rst1;
  uc_mc_param_if #(.STATE_W(7)) b0 ();
  uc_mc_param_if #(.STATE_W(7)) b1 ();

  uc_mc_param #(.MEM_WAIT(0), .STATE_W(7)) dut0 (.CLK(CLK), .RESET(rst0), .bus(b0.master));
  uc_mc_param #(.MEM_WAIT(2), .STATE_W(7)) dut1 (.CLK(CLK), .RESET(rst1), .bus(b1.master));

  obs_t obs0, obs1;
  assign obs0 = '{st: b0.ESTADO_ATUAL, pc_write: b0.PC_WRITE, ir_write: b0.IR_WRITE,
                  load_a: b0.LOAD_A, load_b: b0.LOAD_B, load_aluout: b0.LOAD_ALUOUT,
                  load_mdr: b0.LOAD_MDR, write_reg: b0.WRITE_REG, mem_to_reg: b0.MEM_TO_REG,
                  dmem_rw: b0.DMEM_RW, alu_srca: b0.ALU_SRCA, reset_wire: b0.RESET_WIRE,
                  exception: b0.EXCEPTION, alu_srcb: b0.ALU_SRCB, pc_src: b0.PC_SRC,
                  alu_sel: b0.ALU_SELECTOR};
  assign obs1 = '{st: b1.ESTADO_ATUAL, pc_write: b1.PC_WRITE, ir_write: b1.IR_WRITE,
                  load_a: b1.LOAD_A, load_b: b1.LOAD_B, load_aluout: b1.LOAD_ALUOUT,
                  load_mdr: b1.LOAD_MDR, write_reg: b1.WRITE_REG, mem_to_reg: b1.MEM_TO_REG,
                  dmem_rw: b1.DMEM_RW, alu_srca: b1.ALU_SRCA, reset_wire: b1.RESET_WIRE,
                  exception: b1.EXCEPTION, alu_srcb: b1.ALU_SRCB, pc_src: b1.PC_SRC,
                  alu_sel: b1.ALU_SELECTOR};

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];
  logic [6:0] after_st;

  function automatic obs_t blank(input state_t s);
    obs_t o;
    o = '0;
    o.st = 7'(s);
    return o;
  endfunction

  // Expected per-cycle trace for one instruction, starting at the first fetch cycle.
  task automatic build_trace(input int w, input logic [31:0] ir, input logic z);
    obs_t o;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit illegal;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25];
    illegal = 1'b0;
    exp_q.delete();
    for (int i = 0; i <= w; i++) begin
      o = blank(BUSCA); o.ir_write = (i == w); exp_q.push_back(o);
    end
    o = blank(SOMA); o.pc_write = 1; o.alu_srcb = 1; o.alu_sel = 1; exp_q.push_back(o);
    o = blank(DECODE); o.load_a = 1; o.load_b = 1; o.load_aluout = 1;
    o.alu_srcb = 3; o.alu_sel = 1; exp_q.push_back(o);
    case (op)
      7'b0110011: begin
        o = blank(R); o.alu_srca = 1; o.load_aluout = 1;
        if (f7 == 7'h00) o.alu_sel = 1;
        else if (f7 == 7'h20) o.alu_sel = 2;
        else illegal = 1'b1;
        exp_q.push_back(o);
        if (!illegal) begin o = blank(WB_ALU); o.write_reg = 1; exp_q.push_back(o); end
      end
      7'b0010011, 7'b0110111: begin
        o = blank(op == 7'b0010011 ? ADDI : LUI);
        o.alu_srca = (op == 7'b0010011); o.alu_srcb = 2;
        o.alu_sel = (op == 7'b0010011) ? 3'd1 : 3'd0; o.load_aluout = 1;
        exp_q.push_back(o);
        o = blank(WB_ALU); o.write_reg = 1; exp_q.push_back(o);
      end
      7'b0000011, 7'b0100011: begin
        o = blank(op == 7'b0000011 ? LD_ADDR : SD_ADDR);
        o.alu_srca = 1; o.alu_srcb = 2; o.alu_sel = 1; o.load_aluout = 1;
        exp_q.push_back(o);
        for (int i = 0; i <= w; i++) begin
          if (op == 7'b0000011) begin
            o = blank(LD_WAIT); o.load_mdr = (i == w);
          end else begin
            o = blank(SD_WAIT); o.dmem_rw = 1;
          end
          exp_q.push_back(o);
        end
        if (op == 7'b0000011) begin
          o = blank(LD_WB); o.write_reg = 1; o.mem_to_reg = 1; exp_q.push_back(o);
        end
      end
      7'b1100011: begin
        o = blank(BRANCH); o.alu_srca = 1; o.alu_sel = 2;
        if ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z)) begin
          o.pc_write = 1; o.pc_src = 1;
        end
        if (f3 > 3'b001) illegal = 1'b1;
        exp_q.push_back(o);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal && TRAP_EN) begin
      o = blank(TRAP); o.exception = 1; o.pc_write = 1; o.pc_src = 2; exp_q.push_back(o);
    end
  endtask

  task automatic set_in(input int d, input logic [31:0] ir, input logic z);
    if (d == 0) begin b0.IR31_0 = ir; b0.ZERO = z; end
    else        begin b1.IR31_0 = ir; b1.ZERO = z; end
  endtask

  // Leaves the bench just after the negedge of a RESET_ST cycle with RESET released.
  task automatic do_reset(input int d);
    if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
  endtask

  // Captures exp_q.size() cycles, then the state one cycle later (the next fetch).
  task automatic run_instr(input int d, input logic [31:0] ir, input logic z);
    set_in(d, ir, z);
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      obs_q.push_back(d == 0 ? obs0 : obs1);
    end
    @(posedge CLK);
    #1;
    after_st = (d == 0) ? obs0.st : obs1.st;
  endtask

  task automatic test_reset();
    obs_t e;
    e = blank(RESET_ST); e.reset_wire = 1;
    rst0 = 1'b1; rst1 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_w0 got %h need %h", obs0, e); end
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL reset_w2 got %h need %h", obs1, e); end
    rst0 = 1'b0; rst1 = 1'b0;
  endtask

  task automatic test_add();
    int wr_cnt, wr_idx;
    do_reset(0);
    build_trace(0, 32'h002081B3, 1'b0);
    run_instr(0, 32'h002081B3, 1'b0);
    wr_cnt = 0; wr_idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL add cyc %0d got %h need %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].write_reg) begin wr_cnt++; wr_idx = i; end
    end
    checks++;
    if (after_st !== 7'd1) begin errors++; $display("FAIL add_len next state %0d need 1", after_st); end
    checks++;
    if (obs_q[3].alu_sel !== 3'd1) begin errors++; $display("FAIL add_sel got %0d need 1", obs_q[3].alu_sel); end
    checks++;
    if (wr_cnt != 1 || wr_idx != 4) begin
      errors++; $display("FAIL add_wr count %0d at %0d need 1 at 4", wr_cnt, wr_idx);
    end
  endtask

  task automatic test_ld();
    int mdr_cnt, mdr_idx;
    do_reset(1);
    build_trace(2, 32'h0000B183, 1'b0);
    run_instr(1, 32'h0000B183, 1'b0);
    mdr_cnt = 0; mdr_idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ld cyc %0d got %h need %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].load_mdr) begin mdr_cnt++; mdr_idx = i; end
    end
    checks++;
    if (obs_q.size() != 10 || after_st !== 7'd1) begin
      errors++; $display("FAIL ld_len cycles %0d next %0d need 10 then 1", obs_q.size(), after_st);
    end
    checks++;
    if (mdr_cnt != 1 || mdr_idx != 8) begin
      errors++; $display("FAIL ld_mdr count %0d at %0d need 1 at 8", mdr_cnt, mdr_idx);
    end
    checks++;
    if (obs_q[9].mem_to_reg !== 1'b1) begin errors++; $display("FAIL ld_m2r got %b need 1", obs_q[9].mem_to_reg); end
  endtask

  task automatic test_branch();
    logic [31:0] irs [5] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463, 32'h0020A463};
    logic        zs  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 5; t++) begin
      do_reset(0);
      build_trace(0, irs[t], zs[t]);
      run_instr(0, irs[t], zs[t]);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL branch%0d cyc %0d got %h need %h", t, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (obs_q[3].pc_write !== tk[t] || obs_q[3].pc_src !== (tk[t] ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL branch%0d_taken pc_write %b pc_src %0d need %b", t,
                            obs_q[3].pc_write, obs_q[3].pc_src, tk[t]);
      end
    end
  endtask

  task automatic test_illegal();
    int exc;
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      build_trace(d * 2, 32'h0000007F, 1'b0);
      run_instr(d, 32'h0000007F, 1'b0);
      exc = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL illegal_d%0d cyc %0d got %h need %h", d, i, obs_q[i], exp_q[i]);
        end
        if (obs_q[i].exception) exc++;
      end
      checks++;
      if (exc != (TRAP_EN ? 1 : 0) || after_st !== 7'd1) begin
        errors++; $display("FAIL illegal_d%0d_exc pulses %0d next %0d need %0d then 1", d, exc,
                            after_st, TRAP_EN ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_in_sd_wait();
    obs_t e;
    do_reset(1);
    build_trace(2, 32'h0020B023, 1'b0);
    set_in(1, 32'h0020B023, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if (obs1 !== exp_q[i]) begin
        errors++; $display("FAIL sd_pre cyc %0d got %h need %h", i, obs1, exp_q[i]);
      end
    end
    rst1 = 1'b1;
    @(negedge CLK);
    e = blank(RESET_ST); e.reset_wire = 1;
    checks++;
    if (obs1 !== e || obs1.dmem_rw !== 1'b0) begin
      errors++; $display("FAIL sd_reset got %h need %h", obs1, e);
    end
    rst1 = 1'b0;
    // A fresh load must get the full fetch and wait lengths, proving the counter was cleared.
    build_trace(2, 32'h0000B183, 1'b0);
    run_instr(1, 32'h0000B183, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sd_after cyc %0d got %h need %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rnd, ir;
    logic z;
    int k;
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      for (int n = 0; n < 15; n++) begin
        rnd = $urandom;
        k = $urandom_range(0, 5);
        z = 1'($urandom_range(0, 1));
        case (k)
          0: ir = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rnd[24:7], 7'b0110011};
          1: ir = {rnd[31:7], 7'b0010011};
          2: ir = {rnd[31:7], 7'b0000011};
          3: ir = {rnd[31:7], 7'b0100011};
          4: ir = {rnd[31:15], 2'b00, rnd[12], rnd[11:7], 7'b1100011};
          default: ir = {rnd[31:7], 7'b0110111};
        endcase
        build_trace(d * 2, ir, z);
        run_instr(d, ir, z);
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand_d%0d ir %h cyc %0d got %h need %h", d, ir, i, obs_q[i], exp_q[i]);
          end
        end
        checks++;
        if (after_st !== 7'd1) begin
          errors++; $display("FAIL rand_d%0d_end ir %h next %0d need 1", d, ir, after_st);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    set_in(0, 32'h0, 1'b0);
    set_in(1, 32'h0, 1'b0);
    test_reset();
    test_add();
    test_ld();
    test_branch();
    test_illegal();
    test_reset_in_sd_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
